bdm_cmd_engine: RTL and testbench
=================================

# bdm_cmd_engine

Parametrised command sequencer for the BDM debug link. It replaces the single-byte, single-shot top-level control FSM with queued burst reads and writes, streamed write data, and a widened delay counter. It adds a per-wait watchdog with a sticky error flag. It drives the startup, SYNC, BDC-clock and BDC-interface sub-blocks through strobes and consumes their completion pulses.

## Interface
- DATA_W, 8, BDC byte width
- LEN_W, 4, burst length field width (max burst 2^LEN_W-1 bytes)
- DELAY_SHIFT, 4, delay scale; delay cycles = cmd_data << DELAY_SHIFT
- TIMEOUT_W, 16, watchdog width; timeout fires after 2^TIMEOUT_W-1 cycles
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- cmd_valid / cmd_ready  in / out  1  command handshake; transfer when both are high at a rising edge
- cmd_op  in  3  opcode: 0 NOP, 1 START, 2 STOP, 3 READ, 4 WRITE, 5 DELAY, 6 ECHO, 7 illegal
- cmd_len  in  LEN_W  byte count for READ/WRITE
- cmd_data  in  DATA_W  DELAY count or ECHO byte
- wr_valid / wr_ready  in / out  1  write-byte stream handshake; wr_data  in  DATA_W
- rd_valid  out  1  one-cycle strobe per returned byte; rd_data  out  DATA_W
- cmd_done  out  1  one-cycle strobe on command completion (including aborts)
- error  out  1  sticky; cleared when the next command is accepted
- busy  out  1  high whenever state is not IDLE
- mcu_running  out  1  set by a completed START; cleared by STOP or rst
- startup_start, startup_stop, sync_start, set_sync_len, bdc_read, bdc_send  out  1  one-cycle registered strobes
- startup_ready, sync_ready, bdc_ready  in  1  one-cycle completion pulses from the sub-blocks
- bdc_data_tx  out  DATA_W; bdc_data_rx  in  DATA_W
- state  out  4  debug view of the current state encoding

## Operation
- States: IDLE, BOOT, SYNC, STOP, RD_ISSUE, RD_WAIT, WR_FETCH, WR_WAIT, DELAY, ECHO.
- cmd_ready = (state==IDLE) && !rst. A command accepted at edge T is visible in its first state at T+1.
- **START:**
  - BOOT: pulse startup_start on entry, then wait for startup_ready.
  - SYNC: pulse sync_start on entry, then wait for sync_ready.
  - On sync_ready: pulse set_sync_len, set mcu_running=1, go to IDLE.
- **STOP:** one cycle in STOP with startup_stop high and mcu_running cleared, then IDLE.
- **READ, cmd_len=N:**
  - Load remaining=N.
  - RD_ISSUE: pulse bdc_read, go to RD_WAIT.
  - RD_WAIT, on bdc_ready: rd_data<=bdc_data_rx, rd_valid=1 on the next cycle, remaining--.
  - Then RD_ISSUE again if remaining≠0, else IDLE.
- **WRITE, cmd_len=N:**
  - WR_FETCH: wr_ready=1. On the wr handshake, latch bdc_data_tx and go to WR_WAIT with bdc_send pulsed on entry.
  - WR_WAIT: on bdc_ready, loop back to WR_FETCH or go to IDLE, as for READ.
- **READ/WRITE edge cases:**
  - N=0: no bus activity; the command completes as a NOP.
  - mcu_running=0: no bus activity; error=1 and the command completes.
- **DELAY:**
  - Counter is DATA_W+DELAY_SHIFT bits, loaded with cmd_data<<DELAY_SHIFT; no truncation.
  - Decrement each cycle; leave the cycle after the counter reads 0.
- **ECHO:** one cycle in ECHO with rd_valid=1 and rd_data=cmd_data.
- **NOP / illegal:** complete immediately. Opcode 7 also sets error.
- **Watchdog:**
  - Counter clears on every state entry.
  - Runs in BOOT, SYNC, RD_WAIT, WR_FETCH and WR_WAIT.
  - At 2^TIMEOUT_W-1: go to IDLE, set error=1, pulse cmd_done, emit no further strobes, discard remaining bytes.
- Sub-block ready pulses arriving outside their wait state are ignored.

## Timing
- Reset: state=IDLE; all strobes, rd_valid, cmd_done, error, busy and mcu_running are 0; rd_data=0 and bdc_data_tx=0. Reset asserted mid-command aborts it with no cmd_done.
- cmd_done is asserted in the first cycle state is IDLE again. NOP, illegal and N=0 commands: cmd_done at T+1, cmd_ready high again at T+1.
- ECHO: rd_valid at T+1, cmd_done at T+2.
- DELAY d: state leaves DELAY after (d<<DELAY_SHIFT)+1 cycles.
- READ: bdc_read at T+1. bdc_ready at cycle R gives rd_valid at R+1. The next bdc_read is also at R+1, so there is 1 cycle between bytes.
- A command cannot be accepted in the same cycle cmd_done is asserted for a command that ended via a non-IDLE state.
- Strobes are never asserted while rst is high.

## Test plan
- rst, then START: startup_ready 10 cycles after startup_start, sync_ready 20 cycles after sync_start → set_sync_len one pulse, mcu_running=1, cmd_done once, error=0.
- After START, READ N=3 with bdc_ready 5 cycles after each bdc_read, rx bytes 0xA1, 0xB2, 0xC3 → exactly 3 bdc_read strobes, rd_valid×3 with those bytes in order, then cmd_done.
- After START, WRITE N=2 with wr_valid delayed 4 cycles on the first byte and bytes 0x5A, 0x3C → bdc_send×2 with bdc_data_tx matching, wr_ready only in WR_FETCH.
- DELAY cmd_data=0xFF, DELAY_SHIFT=4 → busy for exactly 4081 cycles; confirms no 8-bit truncation. ECHO 0x42 → rd_data=0x42 at T+1.
- READ with mcu_running=0 → error=1, no bdc_read, cmd_done at T+1. Opcode 7 → error=1. Next ECHO clears error.
- READ with bdc_ready never asserted, TIMEOUT_W=4 → abort after 15 cycles in RD_WAIT, error=1. rst mid-BOOT → IDLE, no cmd_done.

Source files
------------

// File: rtl/bdm_cmd_engine.sv
// Command sequencer for the BDM debug link: queued burst reads/writes, delays and echo,
// driving the startup, SYNC and BDC sub-blocks through strobes with a per-wait watchdog.
module bdm_cmd_engine #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned LEN_W       = 4,
    parameter int unsigned DELAY_SHIFT = 4,
    parameter int unsigned TIMEOUT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              cmd_done,
    output logic              error,
    output logic              busy,
    output logic              mcu_running,
    output logic              startup_start,
    output logic              startup_stop,
    output logic              sync_start,
    output logic              set_sync_len,
    output logic              bdc_read,
    output logic              bdc_send,
    input  logic              startup_ready,
    input  logic              sync_ready,
    input  logic              bdc_ready,
    output logic [DATA_W-1:0] bdc_data_tx,
    input  logic [DATA_W-1:0] bdc_data_rx,
    output logic [3:0]        state
);

    localparam int unsigned CNT_W = DATA_W + DELAY_SHIFT;
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    localparam logic [2:0] OP_START = 3'd1;
    localparam logic [2:0] OP_STOP  = 3'd2;
    localparam logic [2:0] OP_READ  = 3'd3;
    localparam logic [2:0] OP_WRITE = 3'd4;
    localparam logic [2:0] OP_DELAY = 3'd5;
    localparam logic [2:0] OP_ECHO  = 3'd6;
    localparam logic [2:0] OP_ILL   = 3'd7;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_BOOT     = 4'd1,
        S_SYNC     = 4'd2,
        S_STOP     = 4'd3,
        S_RD_ISSUE = 4'd4,
        S_RD_WAIT  = 4'd5,
        S_WR_FETCH = 4'd6,
        S_WR_WAIT  = 4'd7,
        S_DELAY    = 4'd8,
        S_ECHO     = 4'd9
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0]    dly_q, dly_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d, tx_q, tx_d;
    logic                rd_valid_q, rd_valid_d, done_q, done_d, ret_q, ret_d;
    logic                error_q, error_d, busy_q, busy_d, mcu_q, mcu_d, wr_ready_q, wr_ready_d;
    logic                st_start_q, st_start_d, st_stop_q, st_stop_d, sy_start_q, sy_start_d;
    logic                ssl_q, ssl_d, rd_q, rd_d, snd_q, snd_d;
    logic                accept, in_wait, wd_expired, imm_done;

    // A command that just returned from a busy state blocks acceptance for its done cycle
    assign cmd_ready  = (state_q == S_IDLE) && !rst && !ret_q;
    assign accept     = cmd_valid && cmd_ready;
    assign in_wait    = state_q inside {S_BOOT, S_SYNC, S_RD_WAIT, S_WR_FETCH, S_WR_WAIT};
    assign wd_expired = in_wait && (wd_q == WD_LAST);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        dly_d      = dly_q;
        rd_data_d  = rd_data_q;
        tx_d       = tx_q;
        error_d    = error_q;
        mcu_d      = mcu_q;
        rd_valid_d = 1'b0;
        st_start_d = 1'b0;
        st_stop_d  = 1'b0;
        sy_start_d = 1'b0;
        ssl_d      = 1'b0;
        rd_d       = 1'b0;
        snd_d      = 1'b0;
        imm_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    error_d = 1'b0;
                    case (cmd_op)
                        OP_START: begin
                            state_d    = S_BOOT;
                            st_start_d = 1'b1;
                        end
                        OP_STOP: begin
                            state_d   = S_STOP;
                            st_stop_d = 1'b1;
                            mcu_d     = 1'b0;
                        end
                        OP_READ, OP_WRITE: begin
                            rem_d = cmd_len;
                            if (cmd_len == '0) begin
                                imm_done = 1'b1;
                            end else if (!mcu_q) begin
                                error_d  = 1'b1;
                                imm_done = 1'b1;
                            end else if (cmd_op == OP_READ) begin
                                state_d = S_RD_ISSUE;
                                rd_d    = 1'b1;
                            end else begin
                                state_d = S_WR_FETCH;
                            end
                        end
                        OP_DELAY: begin
                            state_d = S_DELAY;
                            dly_d   = CNT_W'(cmd_data) << DELAY_SHIFT;
                        end
                        OP_ECHO: begin
                            state_d    = S_ECHO;
                            rd_valid_d = 1'b1;
                            rd_data_d  = cmd_data;
                        end
                        OP_ILL: begin
                            error_d  = 1'b1;
                            imm_done = 1'b1;
                        end
                        default: imm_done = 1'b1;
                    endcase
                end
            end
            S_BOOT: if (startup_ready) begin
                state_d    = S_SYNC;
                sy_start_d = 1'b1;
            end
            S_SYNC: if (sync_ready) begin
                state_d = S_IDLE;
                ssl_d   = 1'b1;
                mcu_d   = 1'b1;
            end
            S_STOP:     state_d = S_IDLE;
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT: if (bdc_ready) begin
                rd_valid_d = 1'b1;
                rd_data_d  = bdc_data_rx;
                rem_d      = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RD_ISSUE;
                    rd_d    = 1'b1;
                end
            end
            S_WR_FETCH: if (wr_valid) begin
                tx_d    = wr_data;
                state_d = S_WR_WAIT;
                snd_d   = 1'b1;
            end
            S_WR_WAIT: if (bdc_ready) begin
                rem_d   = rem_q - LEN_W'(1);
                state_d = (rem_q == LEN_W'(1)) ? S_IDLE : S_WR_FETCH;
            end
            S_DELAY: begin
                if (dly_q == '0) state_d = S_IDLE;
                else             dly_d   = dly_q - CNT_W'(1);
            end
            S_ECHO:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Watchdog abort only when the wait state saw no completion this cycle
        if (wd_expired && (state_d == state_q)) begin
            state_d = S_IDLE;
            error_d = 1'b1;
        end

        wd_d       = (in_wait && (state_d == state_q)) ? wd_q + TIMEOUT_W'(1) : '0;
        ret_d      = (state_q != S_IDLE) && (state_d == S_IDLE);
        done_d     = ret_d || imm_done;
        busy_d     = (state_d != S_IDLE);
        wr_ready_d = (state_d == S_WR_FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            dly_q      <= '0;
            wd_q       <= '0;
            rd_data_q  <= '0;
            tx_q       <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            ret_q      <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
            mcu_q      <= 1'b0;
            wr_ready_q <= 1'b0;
            st_start_q <= 1'b0;
            st_stop_q  <= 1'b0;
            sy_start_q <= 1'b0;
            ssl_q      <= 1'b0;
            rd_q       <= 1'b0;
            snd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            dly_q      <= dly_d;
            wd_q       <= wd_d;
            rd_data_q  <= rd_data_d;
            tx_q       <= tx_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            ret_q      <= ret_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
            mcu_q      <= mcu_d;
            wr_ready_q <= wr_ready_d;
            st_start_q <= st_start_d;
            st_stop_q  <= st_stop_d;
            sy_start_q <= sy_start_d;
            ssl_q      <= ssl_d;
            rd_q       <= rd_d;
            snd_q      <= snd_d;
        end
    end

    // Strobes are masked during reset so a pulse launched before reset never leaks out
    assign startup_start = st_start_q && !rst;
    assign startup_stop  = st_stop_q  && !rst;
    assign sync_start    = sy_start_q && !rst;
    assign set_sync_len  = ssl_q      && !rst;
    assign bdc_read      = rd_q       && !rst;
    assign bdc_send      = snd_q      && !rst;

    assign wr_ready    = wr_ready_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign cmd_done    = done_q;
    assign error       = error_q;
    assign busy        = busy_q;
    assign mcu_running = mcu_q;
    assign bdc_data_tx = tx_q;
    assign state       = state_q;

endmodule

// File: tb/tb_bdm_cmd_engine.sv
// Scoreboard bench for bdm_cmd_engine: behavioural sub-block responders, expected read and
// write bytes queued at stimulus time and checked when the engine produces them.
module tb_bdm_cmd_engine;

    localparam int unsigned TO_W = 5;
    localparam int WD_CYC = (1 << TO_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_len = '0;
    logic [7:0] cmd_data = '0;
    logic       wr_valid = 1'b0, wr_ready;
    logic [7:0] wr_data = '0;
    logic       rd_valid, cmd_done, error, busy, mcu_running;
    logic [7:0] rd_data, bdc_data_tx;
    logic       startup_start, startup_stop, sync_start, set_sync_len, bdc_read, bdc_send;
    logic       startup_ready = 1'b0, sync_ready = 1'b0, bdc_ready = 1'b0;
    logic [7:0] bdc_data_rx = '0;
    logic [3:0] state;

    bdm_cmd_engine #(.DATA_W(8), .LEN_W(4), .DELAY_SHIFT(4), .TIMEOUT_W(TO_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .cmd_data(cmd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .cmd_done(cmd_done), .error(error), .busy(busy), .mcu_running(mcu_running),
        .startup_start(startup_start), .startup_stop(startup_stop), .sync_start(sync_start),
        .set_sync_len(set_sync_len), .bdc_read(bdc_read), .bdc_send(bdc_send),
        .startup_ready(startup_ready), .sync_ready(sync_ready), .bdc_ready(bdc_ready),
        .bdc_data_tx(bdc_data_tx), .bdc_data_rx(bdc_data_rx), .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_mis = 0;
    int cyc_cnt = 0, acc_cyc = 0, last_rd_cyc = 0;
    int busy_cnt = 0, n_done = 0, n_read = 0, n_send = 0, n_ssl = 0, n_stop = 0;
    int boot_dly = 10, sync_dly = 20, bdc_dly = 5;
    bit bdc_en = 1'b1;
    logic [7:0] exp_rd[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rx_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Output monitor: counts strobes and scores returned/sent bytes
    always @(negedge clk) begin
        if (busy)         busy_cnt++;
        if (cmd_done)     n_done++;
        if (bdc_read)     n_read++;
        if (set_sync_len) n_ssl++;
        if (startup_stop) n_stop++;
        if (rst)
            check("strobe_in_rst", 32'({startup_start, startup_stop, sync_start,
                                        set_sync_len, bdc_read, bdc_send}), 32'd0);
        if (rd_valid) begin
            last_rd_cyc = cyc_cnt;
            if (exp_rd.size() == 0) check("rd_unexpected", 32'(rd_data), 32'hFFFF);
            else                    check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
        end
        if (bdc_send) begin
            n_send++;
            if (exp_tx.size() == 0) check("tx_unexpected", 32'(bdc_data_tx), 32'hFFFF);
            else                    check("bdc_data_tx", 32'(bdc_data_tx), 32'(exp_tx.pop_front()));
        end
        if (wr_ready) check("wr_ready_state", 32'(state), 32'd6);
    end

    initial begin : startup_model
        forever begin
            @(negedge clk);
            if (startup_start) begin
                repeat (boot_dly) @(posedge clk);
                #1 startup_ready = 1'b1;
                @(posedge clk);
                #1 startup_ready = 1'b0;
            end
        end
    end

    initial begin : sync_model
        forever begin
            @(negedge clk);
            if (sync_start) begin
                repeat (sync_dly) @(posedge clk);
                #1 sync_ready = 1'b1;
                @(posedge clk);
                #1 sync_ready = 1'b0;
            end
        end
    end

    initial begin : bdc_model
        forever begin
            @(negedge clk);
            if ((bdc_read || bdc_send) && bdc_en) begin
                repeat (bdc_dly) @(posedge clk);
                #1;
                bdc_data_rx = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
                bdc_ready   = 1'b1;
                @(posedge clk);
                #1 bdc_ready = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [3:0] len, input logic [7:0] data);
        logic ok;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        acc_cyc   = cyc_cnt;
        if (!ok) check("cmd_accept", 32'd0, 32'd1);
    endtask

    // Returns the cycle of cmd_done counted from the accepting edge (1 = T+1)
    task automatic wait_done(input int limit, output int rel);
        rel = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (cmd_done) begin
                rel = cyc_cnt - acc_cyc + 1;
                break;
            end
        end
        if (rel == 0) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int dly, input logic [7:0] d);
        logic hs;
        idle(dly);
        wr_valid = 1'b1;
        wr_data  = d;
        hs       = 1'b0;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge clk);
            hs = wr_ready;
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        if (!hs) check("wr_handshake", 32'd0, 32'd1);
    endtask

    initial begin : main
        int rel, base_rd, base_snd, base_done, base_ssl, base_stop;

        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_flags", 32'({busy, error, mcu_running, rd_valid, cmd_done}), 32'd0);
        check("rst_data", 32'({rd_data, bdc_data_tx}), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        // START: BOOT 11 cycles, SYNC 21 cycles, done on the first IDLE cycle
        base_ssl = n_ssl; base_done = n_done;
        send_cmd(3'd1, 4'd0, 8'h00);
        wait_done(200, rel);
        check("start_done_cyc", 32'(rel), 32'd33);
        check("start_mcu", 32'(mcu_running), 32'd1);
        check("start_error", 32'(error), 32'd0);
        idle(3);
        check("start_ssl_cnt", 32'(n_ssl - base_ssl), 32'd1);
        check("start_done_cnt", 32'(n_done - base_done), 32'd1);

        // READ 3 bytes, bdc_ready 5 cycles after each bdc_read
        base_rd = n_read;
        rx_q.push_back(8'hA1); rx_q.push_back(8'hB2); rx_q.push_back(8'hC3);
        exp_rd.push_back(8'hA1); exp_rd.push_back(8'hB2); exp_rd.push_back(8'hC3);
        send_cmd(3'd3, 4'd3, 8'h00);
        wait_done(200, rel);
        check("read_done_cyc", 32'(rel), 32'd19);
        check("read_cnt", 32'(n_read - base_rd), 32'd3);
        check("read_all_seen", 32'(exp_rd.size()), 32'd0);

        // WRITE 2 bytes, first wr_valid 4 cycles late
        base_snd = n_send;
        exp_tx.push_back(8'h5A); exp_tx.push_back(8'h3C);
        send_cmd(3'd4, 4'd2, 8'h00);
        push_wr(4, 8'h5A);
        push_wr(0, 8'h3C);
        wait_done(200, rel);
        check("write_done_cyc", 32'(rel), 32'd19);
        check("write_send_cnt", 32'(n_send - base_snd), 32'd2);
        check("write_all_seen", 32'(exp_tx.size()), 32'd0);

        // DELAY 0xFF << 4: busy for 4080+1 cycles
        busy_cnt = 0;
        send_cmd(3'd5, 4'd0, 8'hFF);
        wait_done(5000, rel);
        check("delay_busy", 32'(busy_cnt), 32'd4081);
        check("delay_done_cyc", 32'(rel), 32'd4082);

        // ECHO: rd_valid at T+1, done at T+2
        exp_rd.push_back(8'h42);
        send_cmd(3'd6, 4'd0, 8'h42);
        wait_done(20, rel);
        check("echo_done_cyc", 32'(rel), 32'd2);
        check("echo_rd_cyc", 32'(last_rd_cyc - acc_cyc + 1), 32'd1);

        // STOP clears mcu_running
        base_stop = n_stop;
        send_cmd(3'd2, 4'd0, 8'h00);
        wait_done(20, rel);
        check("stop_done_cyc", 32'(rel), 32'd2);
        check("stop_mcu", 32'(mcu_running), 32'd0);
        check("stop_strobe_cnt", 32'(n_stop - base_stop), 32'd1);

        // READ while stopped: immediate completion with error, no bus activity
        base_rd = n_read;
        send_cmd(3'd3, 4'd3, 8'h00);
        wait_done(20, rel);
        check("rd_stopped_done", 32'(rel), 32'd1);
        idle(8);
        check("rd_stopped_err", 32'(error), 32'd1);
        check("rd_stopped_noread", 32'(n_read - base_rd), 32'd0);

        // NOP clears error; opcode 7 sets it; ECHO clears it again
        send_cmd(3'd0, 4'd0, 8'h00);
        wait_done(20, rel);
        check("nop_done_cyc", 32'(rel), 32'd1);
        check("nop_err_clr", 32'(error), 32'd0);
        send_cmd(3'd7, 4'd0, 8'h00);
        wait_done(20, rel);
        check("ill_done_cyc", 32'(rel), 32'd1);
        check("ill_err", 32'(error), 32'd1);
        exp_rd.push_back(8'h17);
        send_cmd(3'd6, 4'd0, 8'h17);
        wait_done(20, rel);
        check("echo_err_clr", 32'(error), 32'd0);

        // Watchdog: restart link, then READ whose bdc_ready never comes
        send_cmd(3'd1, 4'd0, 8'h00);
        wait_done(200, rel);
        check("restart_mcu", 32'(mcu_running), 32'd1);
        bdc_en  = 1'b0;
        base_rd = n_read;
        send_cmd(3'd3, 4'd2, 8'h00);
        wait_done(200, rel);
        check("wd_done_cyc", 32'(rel), 32'(WD_CYC + 2));
        check("wd_error", 32'(error), 32'd1);
        idle(10);
        check("wd_read_cnt", 32'(n_read - base_rd), 32'd1);
        bdc_en = 1'b1;

        // Reset in the middle of BOOT: back to IDLE without cmd_done
        send_cmd(3'd1, 4'd0, 8'h00);
        idle(3);
        check("boot_state", 32'(state), 32'd1);
        base_done = n_done;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(40);
        check("rst_boot_state", 32'(state), 32'd0);
        check("rst_boot_busy", 32'(busy), 32'd0);
        check("rst_boot_mcu", 32'(mcu_running), 32'd0);
        check("rst_boot_nodone", 32'(n_done - base_done), 32'd0);
        check("rd_leftover", 32'(exp_rd.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
